// File: rtl/interleaver_pkg.sv
// ============================================================================
// Package     : interleaver_pkg
// Description : Shared block sizes, CRC polynomials, state and block-size
//               encodings for the CRC attach stage and interleaver_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package interleaver_pkg;

  localparam int K_SMALL = 1056;
  localparam int K_LARGE = 6144;
  localparam int CRC_W   = 24;
  localparam int CNT_W   = 13;

  localparam logic [CRC_W-1:0] CRC_POLY    = 24'h864CFB;  // CRC-24A
  localparam logic [CRC_W-1:0] CRC24B_POLY = 24'h800063;  // CRC-24B

  // Block-size code as seen on interleaver_fsm block_size
  localparam logic BS_SMALL = 1'b0;
  localparam logic BS_LARGE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CRC   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Index of the last payload bit for the given block-size code
  function automatic logic [CNT_W-1:0] last_payload_idx(input logic size);
    return (size == BS_LARGE) ? CNT_W'(K_LARGE - CRC_W - 1)
                              : CNT_W'(K_SMALL - CRC_W - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc24_lfsr.sv
// ============================================================================
// Module      : crc24_lfsr
// Description : MSB-first CRC-24 LFSR; compute mode folds din in, drain mode
//               shifts the remainder out on dout, zero-filling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc24_lfsr
  import interleaver_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             mode,
  input  logic             din,
  input  logic [CRC_W-1:0] poly,
  output logic             dout
);

  logic [CRC_W-1:0] r_lfsr;
  logic             w_fb;

  // Forcing feedback low in drain mode turns the update into a plain shift
  assign w_fb = ~mode & (din ^ r_lfsr[CRC_W-1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= '0;
    end else if (clr) begin
      r_lfsr <= '0;
    end else if (shift_en) begin
      r_lfsr <= {r_lfsr[CRC_W-2:0], 1'b0} ^ (w_fb ? poly : '0);
    end
  end

  assign dout = r_lfsr[CRC_W-1];

endmodule

`default_nettype wire

// File: rtl/crc24_attach.sv
// ============================================================================
// Module      : crc24_attach
// Description : Accepts a serial payload, appends CRC-24 and streams the
//               K-bit block to interleaver_fsm. Optional CRC24_POLY_SEL_EN
//               adds in_poly_sel to choose CRC-24B per block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc24_attach
  import interleaver_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic in_start,
  input  logic in_size,
`ifdef CRC24_POLY_SEL_EN
  input  logic in_poly_sel,
`endif
  input  logic in_valid,
  input  logic in_data,
  output logic in_ready,
  output logic crc_start,
  output logic block_size,
  output logic crc_valid,
  output logic crc_data,
  output logic crc_end,
  output logic busy,
  output logic err
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_size;
  logic             r_crc_start;
  logic             r_crc_valid;
  logic             r_crc_data;
  logic             w_accept;
  logic             w_abort;
  logic             w_last_pay;
  logic             w_last_crc;
  logic             w_in_crc;
  logic             w_lfsr_out;
  logic [CRC_W-1:0] w_poly;

  assign w_accept   = (r_state == ST_DATA) & in_valid;
  assign w_abort    = (r_state == ST_DATA) & ~in_valid;
  assign w_last_pay = w_accept & (r_cnt == last_payload_idx(r_size));
  assign w_in_crc   = (r_state == ST_CRC);
  assign w_last_crc = w_in_crc & (r_cnt == CNT_W'(CRC_W - 1));

`ifdef CRC24_POLY_SEL_EN
  logic r_poly_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poly_sel <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_poly_sel <= in_start & in_poly_sel;
    end
  end

  assign w_poly = r_poly_sel ? CRC24B_POLY : CRC_POLY;
`else
  assign w_poly = CRC_POLY;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (in_start) w_next = ST_START;
      ST_START: w_next = ST_WAIT;
      ST_WAIT:  w_next = ST_DATA;
      // Abort is checked first so a stall on the last bit still aborts
      ST_DATA: begin
        if (w_abort)         w_next = ST_IDLE;
        else if (w_last_pay) w_next = ST_CRC;
      end
      ST_CRC:   if (w_last_crc) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // One counter serves both phases: payload index, then CRC bit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if ((w_accept & ~w_last_pay) | (w_in_crc & ~w_last_crc)) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_size <= BS_SMALL;
    end else if (r_state == ST_IDLE) begin
      r_size <= in_start ? in_size : BS_SMALL;
    end
  end

  crc24_lfsr u_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      ((r_state == ST_START) | w_abort),
    .shift_en (w_accept | w_in_crc),
    .mode     (w_in_crc),
    .din      (in_data),
    .poly     (w_poly),
    .dout     (w_lfsr_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc_start <= 1'b0;
      r_crc_valid <= 1'b0;
      r_crc_data  <= 1'b0;
    end else begin
      r_crc_start <= (r_state == ST_START);
      r_crc_valid <= w_accept | w_in_crc;
      r_crc_data  <= w_accept ? in_data : (w_in_crc & w_lfsr_out);
    end
  end

  assign in_ready   = (r_state == ST_DATA);
  assign crc_start  = r_crc_start;
  assign block_size = r_size;
  assign crc_valid  = r_crc_valid;
  assign crc_data   = r_crc_data;
  assign crc_end    = w_abort;
  assign err        = w_abort;
  assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_crc24_attach.sv
// ============================================================================
// Module      : tb_crc24_attach
// Description : Directed self-checking bench for crc24_attach; honours
//               CRC24_POLY_SEL_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc24_attach;

  localparam int          KS    = 1056;
  localparam int          KL    = 6144;
  localparam logic [23:0] POLYA = 24'h864CFB;
  localparam logic [23:0] POLYB = 24'h800063;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic in_start = 1'b0;
  logic in_size  = 1'b0;
  logic in_valid = 1'b1;
  logic in_data  = 1'b0;
`ifdef CRC24_POLY_SEL_EN
  logic in_poly_sel = 1'b0;
`endif
  logic in_ready, crc_start, block_size, crc_valid, crc_data, crc_end, busy, err;
  logic [7:0] w_outs;

  assign w_outs = {in_ready, crc_start, block_size, crc_valid, crc_data, crc_end, busy, err};

  always #5 clk = ~clk;

  crc24_attach dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_start   (in_start),
    .in_size    (in_size),
`ifdef CRC24_POLY_SEL_EN
    .in_poly_sel(in_poly_sel),
`endif
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .crc_start  (crc_start),
    .block_size (block_size),
    .crc_valid  (crc_valid),
    .crc_data   (crc_data),
    .crc_end    (crc_end),
    .busy       (busy),
    .err        (err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pidx, abort_at = -1;
  int n_start, start_cyc, bs_at_start, first_v, last_v;
  int n_err, err_cyc, err_ce, n_rdy, rdy_first, req_cyc;
  bit pay[$];
  bit outq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs right after the falling edge, sample outputs 1 ns later
  task automatic step();
    @(negedge clk);
    in_valid = 1'b1;
    if (in_ready) begin
      if (pidx == abort_at) begin
        in_valid = 1'b0;
        abort_at = -1;
      end else begin
        in_data = (pidx < pay.size()) ? pay[pidx] : 1'b0;
        pidx++;
      end
    end
    #1;
    cyc++;
    if (crc_start) begin
      n_start++;
      start_cyc   = cyc;
      bs_at_start = int'(block_size);
    end
    if (in_ready) begin
      if (rdy_first < 0) rdy_first = cyc;
      n_rdy++;
    end
    if (crc_valid) begin
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      outq.push_back(crc_data);
    end
    if (err) begin
      n_err++;
      err_cyc = cyc;
      err_ce  = int'(crc_end);
    end
  endtask

  task automatic clear_stats();
    outq.delete();
    pidx = 0; n_start = 0; start_cyc = 0; bs_at_start = -1;
    first_v = -1; last_v = -1; n_err = 0; err_cyc = -1; err_ce = -1;
    n_rdy = 0; rdy_first = -1;
  endtask

  // kind 0: all zero; 1: xorshift pattern; 2: zeros with a single final 1
  task automatic start_block(input logic sz, input logic ps, input int kind);
    logic [31:0] s;
    int n;
    s = 32'h1234_5678;
    n = (sz ? KL : KS) - 24;
    pay.delete();
    for (int i = 0; i < n; i++) begin
      s = s ^ (s << 13); s = s ^ (s >> 17); s = s ^ (s << 5);
      pay.push_back(kind == 1 ? s[0] : (kind == 2 && i == n - 1));
    end
    in_size = sz;
`ifdef CRC24_POLY_SEL_EN
    in_poly_sel = ps;
`else
    if (ps) $display("note: in_poly_sel unavailable in this build");
`endif
    req_cyc  = cyc;
    in_start = 1'b1;
    step();
    in_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  function automatic logic [23:0] crc24(input bit q[$], input logic [23:0] poly);
    logic [23:0] r;
    logic fb;
    r = '0;
    foreach (q[i]) begin
      fb = q[i] ^ r[23];
      r  = {r[22:0], 1'b0} ^ (fb ? poly : 24'h0);
    end
    return r;
  endfunction

  function automatic logic [23:0] tail24();
    logic [23:0] r;
    r = '0;
    if (outq.size() >= 24)
      for (int i = outq.size() - 24; i < outq.size(); i++) r = {r[22:0], outq[i]};
    return r;
  endfunction

  logic [23:0] exp_crc;
  logic [23:0] poly2;
  int          s1;
  int          n;

  initial begin
    clear_stats();
    repeat (3) step();
    check("reset_outputs", {24'h0, w_outs}, 0);
    reset_n = 1'b1;
    repeat (2) step();
    check("idle_busy", busy, 0);

    // 1: small all-zero block, timing and zero CRC
    clear_stats();
    start_block(1'b0, 1'b0, 0);
    wait_idle(2000);
    check("t1_start_lat", start_cyc - req_cyc, 2);
    check("t1_ready_first", rdy_first - start_cyc, 1);
    check("t1_ready_count", n_rdy, 1032);
    check("t1_valid_first", first_v - start_cyc, 2);
    check("t1_valid_last", last_v - start_cyc, KS + 1);
    check("t1_len", outq.size(), KS);
    check("t1_tail", tail24(), 0);
    check("t1_bsize", bs_at_start, 0);
    check("t1_no_err", n_err, 0);

    // 2: large patterned block
    clear_stats();
    start_block(1'b1, 1'b0, 1);
    exp_crc = crc24(pay, POLYA);
    wait_idle(7000);
    check("t2_bsize", bs_at_start, 1);
    check("t2_len", outq.size(), KL);
    check("t2_valid_last", last_v - start_cyc, KL + 1);
    check("t2_tail", tail24(), exp_crc);
    check("t2_remainder", crc24(outq, POLYA), 0);

    // 3: stall abort at payload bit 500
    clear_stats();
    abort_at = 500;
    start_block(1'b0, 1'b0, 1);
    n = 0;
    while (n_err == 0 && n < 1200) begin
      step();
      n++;
    end
    abort_at = -1;
    check("t3_err_seen", n_err, 1);
    check("t3_crc_end", err_ce, 1);
    check("t3_len_at_abort", outq.size(), 500);
    step();
    check("t3_valid_after", crc_valid, 0);
    step();
    check("t3_busy_after", busy, 0);
    check("t3_err_pulse", n_err, 1);
    repeat (3) step();
    clear_stats();
    start_block(1'b0, 1'b0, 0);
    wait_idle(2000);
    check("t3_restart_len", outq.size(), KS);
    check("t3_restart_tail", tail24(), 0);

    // 4: in_start mid-DATA and in DONE are ignored
    clear_stats();
    start_block(1'b0, 1'b0, 2);
    n = 0;
    while (pidx < 300 && n < 400) begin
      step();
      n++;
    end
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    n = 0;
    while (cyc < start_cyc + KS + 1 && n < 2000) begin
      step();
      n++;
    end
    check("t4_done_busy", busy, 1);
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    repeat (10) step();
    check("t4_one_start", n_start, 1);
    check("t4_len", outq.size(), KS);
    check("t4_tail", tail24(), 24'h864CFB);
    check("t4_idle", busy, 0);

    // 5: asynchronous reset during CRC bit 10
    clear_stats();
    start_block(1'b1, 1'b0, 1);
    n = 0;
    while (outq.size() < 6131 && n < 7000) begin
      step();
      n++;
    end
    check("t5_active", {30'h0, crc_valid, busy}, 3);
    #2 reset_n = 1'b0;
    #1 check("t5_async_out", {24'h0, w_outs}, 0);
    repeat (2) step();
    reset_n = 1'b1;
    clear_stats();
    repeat (20) step();
    check("t5_no_start", n_start, 0);
    check("t5_idle", {24'h0, w_outs}, 0);

    // 6: back-to-back blocks, second on first IDLE cycle
    clear_stats();
    start_block(1'b0, 1'b0, 1);
    exp_crc = crc24(pay, POLYA);
    wait_idle(2000);
    check("t6a_tail", tail24(), exp_crc);
    s1 = start_cyc;
`ifdef CRC24_POLY_SEL_EN
    poly2 = POLYB;
    clear_stats();
    start_block(1'b0, 1'b1, 2);
    wait_idle(2000);
    check("t6b_tail", tail24(), 24'h800063);
`else
    poly2 = POLYA;
    clear_stats();
    start_block(1'b0, 1'b0, 2);
    wait_idle(2000);
    check("t6b_tail", tail24(), 24'h864CFB);
`endif
    check("t6_start_gap", start_cyc - s1, KS + 4);
    check("t6b_len", outq.size(), KS);
    check("t6b_remainder", crc24(outq, poly2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
